// File: rtl/snoop_pkg.sv
// Shared definitions for the snoop trace block: FSM state codes, full-policy
// codes and the packing layout of one trace record.
// The layout grows by a 16-bit timestamp when SNOOP_TRACE_TIMESTAMP_EN is defined.
package snoop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FROZEN  = 2'd2
    } state_t;

    typedef enum bit {
        FULL_RING = 1'b0,
        FULL_STOP = 1'b1
    } full_policy_t;

`ifdef SNOOP_TRACE_TIMESTAMP_EN
    localparam int TS_W = 16;
`else
    localparam int TS_W = 0;
`endif

    // Record layout, LSB first:
    // arg_wr | arg_valid | arg_data | arg_addr | inst_data | inst_addr | ts
    localparam int OFF_ARG_WR    = 0;
    localparam int OFF_ARG_VALID = 1;
    localparam int OFF_ARG_DATA  = 2;

    function automatic int off_arg_addr(int aw, int dw);
        return 2 + dw + 0 * aw;
    endfunction

    function automatic int off_inst_data(int aw, int dw);
        return 2 + dw + aw;
    endfunction

    function automatic int off_inst_addr(int aw, int dw);
        return 2 + 2 * dw + aw;
    endfunction

    function automatic int off_ts(int aw, int dw);
        return 2 + 2 * dw + 2 * aw;
    endfunction

    function automatic int rec_width(int aw, int dw);
        return 2 + 2 * dw + 2 * aw + TS_W;
    endfunction

endpackage

// File: rtl/snoop_fifo.sv
// Synchronous FIFO with clear, occupancy count, simultaneous push/pop and an
// optional overwrite-oldest mode. The head entry is read straight from storage.
// drop pulses for one cycle whenever a push meets a full FIFO without a
// same-cycle pop (record discarded, or oldest overwritten in ring mode).
module snoop_fifo #(
    parameter int W         = 8,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          pop_ok;
    logic          wr_en;
    logic          rd_adv;

    // Decide what this edge does: pop before push, so full+push+pop never overflows.
    always_comb begin
        full   = (count == CW'(DEPTH));
        valid  = (count != '0);
        pop_ok = pop && valid;
        wr_en  = push && (!full || pop_ok || OVERWRITE);
        rd_adv = pop_ok || (push && full && !pop_ok && OVERWRITE);
        drop   = push && full && !pop_ok;
    end

    // Storage, pointers and count; clear empties without scrubbing storage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_en && !rd_adv) begin
                count <= count + CW'(1);
            end else if (rd_adv && !wr_en) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/snoop_trace.sv
// Instruction trace snooper: stages the decoded instruction, builds one record
// per committed instruction and pushes it into a trace FIFO drained by the
// debug port. An address breakpoint freezes capture until CLEAR.
// Optional macro SNOOP_TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp per record
// and the TRACE_TS output.
//
//   state   | meaning
//   IDLE    | no capture; waits for ENABLE
//   CAPTURE | staging and pushing records
//   FROZEN  | breakpoint hit; capture stopped until CLEAR
module snoop_trace
    import snoop_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int DEPTH        = 16,
    parameter bit STOP_ON_FULL = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FETCH,
    input  logic                       DECODE,
    input  logic                       EXECUTE,
    input  logic                       COMMIT,
    input  logic [AW-1:0]              ADDR,
    input  logic [DW-1:0]              DIN,
    input  logic                       RD,
    input  logic                       WR,
    input  logic                       ENABLE,
    input  logic                       CLEAR,
    input  logic                       BP_EN,
    input  logic [AW-1:0]              BP_ADDR,
    input  logic                       POP,
    output logic                       TRACE_VALID,
    output logic [AW-1:0]              TRACE_INST_ADDR,
    output logic [DW-1:0]              TRACE_INST_DATA,
    output logic [AW-1:0]              TRACE_ARG_ADDR,
    output logic [DW-1:0]              TRACE_ARG_DATA,
    output logic                       TRACE_ARG_VALID,
    output logic                       TRACE_ARG_WR,
    output logic [$clog2(DEPTH):0]     TRACE_COUNT,
    output logic                       OVERFLOW,
`ifdef SNOOP_TRACE_TIMESTAMP_EN
    output logic [15:0]                TRACE_TS,
`endif
    output logic                       BP_HIT
);

    localparam int RW            = rec_width(AW, DW);
    localparam int OFF_ARG_ADDR  = off_arg_addr(AW, DW);
    localparam int OFF_INST_DATA = off_inst_data(AW, DW);
    localparam int OFF_INST_ADDR = off_inst_addr(AW, DW);
    localparam bit RING_MODE     = (STOP_ON_FULL == FULL_RING);

    state_t         state;
    state_t         state_nxt;
    logic           phase_ok;
    logic           capture_on;
    logic           push_req;
    logic           bp_match;
    logic           arg_valid;
    logic [AW-1:0]  stage_addr;
    logic [DW-1:0]  stage_data;
    logic [RW-1:0]  push_rec;
    logic [RW-1:0]  head_rec;
    logic           fifo_drop;

`ifdef SNOOP_TRACE_TIMESTAMP_EN
    localparam int OFF_TS = off_ts(AW, DW);
    logic [15:0] ts_cnt;

    // Free-running cycle stamp, wraps naturally.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ENABLE) state_nxt = CAPTURE;
            CAPTURE: begin
                if (bp_match) begin
                    state_nxt = FROZEN;
                end else if (!ENABLE) begin
                    state_nxt = IDLE;
                end
            end
            FROZEN:  if (CLEAR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: capture qualification, push request and breakpoint match.
    // Cycles with more than one phase strobe are ignored rather than half-applied;
    // CLEAR suppresses the push so a cleared FIFO never holds a same-cycle record.
    always_comb begin
        phase_ok   = $onehot0({FETCH, DECODE, EXECUTE, COMMIT});
        capture_on = (state == CAPTURE) && ENABLE && phase_ok;
        push_req   = capture_on && COMMIT && !CLEAR;
        bp_match   = push_req && BP_EN && (stage_addr == BP_ADDR);
    end

    // Instruction staging: latest DECODE wins until the COMMIT consumes it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage_addr <= '0;
            stage_data <= '0;
        end else if (capture_on && DECODE) begin
            stage_addr <= ADDR;
            stage_data <= DIN;
        end
    end

    // Sticky status flags; CLEAR drops both.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            OVERFLOW <= 1'b0;
            BP_HIT   <= 1'b0;
        end else if (CLEAR) begin
            OVERFLOW <= 1'b0;
            BP_HIT   <= 1'b0;
        end else begin
            if (fifo_drop) OVERFLOW <= 1'b1;
            if (bp_match)  BP_HIT   <= 1'b1;
        end
    end

    // Record assembly; argument fields read as zero when no bus access happened.
    always_comb begin
        arg_valid = RD | WR;
        push_rec  = '0;
        push_rec[OFF_INST_ADDR +: AW] = stage_addr;
        push_rec[OFF_INST_DATA +: DW] = stage_data;
        push_rec[OFF_ARG_ADDR  +: AW] = arg_valid ? ADDR : '0;
        push_rec[OFF_ARG_DATA  +: DW] = arg_valid ? DIN  : '0;
        push_rec[OFF_ARG_VALID]       = arg_valid;
        push_rec[OFF_ARG_WR]          = WR;
`ifdef SNOOP_TRACE_TIMESTAMP_EN
        push_rec[OFF_TS +: 16]        = ts_cnt;
`endif
    end

    snoop_fifo #(
        .W         (RW),
        .DEPTH     (DEPTH),
        .OVERWRITE (RING_MODE)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .clear     (CLEAR),
        .push      (push_req),
        .push_data (push_rec),
        .pop       (POP),
        .head_data (head_rec),
        .valid     (TRACE_VALID),
        .count     (TRACE_COUNT),
        .drop      (fifo_drop)
    );

    assign TRACE_INST_ADDR = head_rec[OFF_INST_ADDR +: AW];
    assign TRACE_INST_DATA = head_rec[OFF_INST_DATA +: DW];
    assign TRACE_ARG_ADDR  = head_rec[OFF_ARG_ADDR  +: AW];
    assign TRACE_ARG_DATA  = head_rec[OFF_ARG_DATA  +: DW];
    assign TRACE_ARG_VALID = head_rec[OFF_ARG_VALID];
    assign TRACE_ARG_WR    = head_rec[OFF_ARG_WR];
`ifdef SNOOP_TRACE_TIMESTAMP_EN
    assign TRACE_TS        = head_rec[OFF_TS +: 16];
`endif

endmodule

// File: tb/tb_snoop_trace.sv
// Bench for snoop_trace: two DEPTH=4 instances (stop-on-full and ring) share
// one stimulus stream and are checked every cycle against a queue-based model.
module tb_snoop_trace;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RESET, FETCH, DECODE, EXECUTE, COMMIT;
    logic [15:0] ADDR, DIN, BP_ADDR;
    logic        RD, WR, ENABLE, CLEAR, BP_EN, POP;

    logic        t_v  [2];
    logic [15:0] t_ia [2];
    logic [15:0] t_id [2];
    logic [15:0] t_aa [2];
    logic [15:0] t_ad [2];
    logic        t_av [2];
    logic        t_aw [2];
    logic [2:0]  t_c  [2];
    logic        t_ovf[2];
    logic        t_bp [2];

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    snoop_trace #(.AW(16), .DW(16), .DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) dut_stop (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
        .COMMIT(COMMIT), .ADDR(ADDR), .DIN(DIN), .RD(RD), .WR(WR), .ENABLE(ENABLE),
        .CLEAR(CLEAR), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .POP(POP),
        .TRACE_VALID(t_v[0]), .TRACE_INST_ADDR(t_ia[0]), .TRACE_INST_DATA(t_id[0]),
        .TRACE_ARG_ADDR(t_aa[0]), .TRACE_ARG_DATA(t_ad[0]), .TRACE_ARG_VALID(t_av[0]),
        .TRACE_ARG_WR(t_aw[0]), .TRACE_COUNT(t_c[0]), .OVERFLOW(t_ovf[0]), .BP_HIT(t_bp[0]));

    snoop_trace #(.AW(16), .DW(16), .DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) dut_ring (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
        .COMMIT(COMMIT), .ADDR(ADDR), .DIN(DIN), .RD(RD), .WR(WR), .ENABLE(ENABLE),
        .CLEAR(CLEAR), .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .POP(POP),
        .TRACE_VALID(t_v[1]), .TRACE_INST_ADDR(t_ia[1]), .TRACE_INST_DATA(t_id[1]),
        .TRACE_ARG_ADDR(t_aa[1]), .TRACE_ARG_DATA(t_ad[1]), .TRACE_ARG_VALID(t_av[1]),
        .TRACE_ARG_WR(t_aw[1]), .TRACE_COUNT(t_c[1]), .OVERFLOW(t_ovf[1]), .BP_HIT(t_bp[1]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] ia, id, aa, ad;
        logic        av, aw;
    } rec_t;

    localparam int M_IDLE = 0, M_CAP = 1, M_FROZEN = 2;

    rec_t        mq[2][$];
    bit          m_ovf [2];
    bit          m_bp  [2];
    int          m_mode[2];
    logic [15:0] m_sa  [2];
    logic [15:0] m_sd  [2];

    always @(posedge CLK) begin : model
        bit   cap, push, popk, hit;
        rec_t r;
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                mq[k].delete();
                m_ovf[k]  = 0;
                m_bp[k]   = 0;
                m_mode[k] = M_IDLE;
                m_sa[k]   = '0;
                m_sd[k]   = '0;
            end else begin
                cap  = (m_mode[k] == M_CAP) && ENABLE;
                push = cap && COMMIT && !CLEAR;
                popk = POP && (mq[k].size() > 0);
                hit  = push && BP_EN && (m_sa[k] == BP_ADDR);
                r.ia = m_sa[k];
                r.id = m_sd[k];
                r.av = RD | WR;
                r.aw = WR;
                r.aa = r.av ? ADDR : 16'h0;
                r.ad = r.av ? DIN  : 16'h0;
                if (CLEAR) begin
                    mq[k].delete();
                    m_ovf[k] = 0;
                    m_bp[k]  = 0;
                end else begin
                    if (popk) void'(mq[k].pop_front());
                    if (push) begin
                        if (mq[k].size() < DEPTH) begin
                            mq[k].push_back(r);
                        end else begin
                            m_ovf[k] = 1;
                            if (k == 1) begin
                                void'(mq[k].pop_front());
                                mq[k].push_back(r);
                            end
                        end
                    end
                    if (hit) m_bp[k] = 1;
                end
                case (m_mode[k])
                    M_IDLE:   if (ENABLE) m_mode[k] = M_CAP;
                    M_CAP:    if (hit) m_mode[k] = M_FROZEN;
                              else if (!ENABLE) m_mode[k] = M_IDLE;
                    default:  if (CLEAR) m_mode[k] = M_IDLE;
                endcase
                if (cap && DECODE) begin
                    m_sa[k] = ADDR;
                    m_sd[k] = DIN;
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check("valid", k, 32'(t_v[k]), 32'(mq[k].size() != 0));
                check("count", k, 32'(t_c[k]), 32'(mq[k].size()));
                check("overflow", k, 32'(t_ovf[k]), 32'(m_ovf[k]));
                check("bp_hit", k, 32'(t_bp[k]), 32'(m_bp[k]));
                if (mq[k].size() != 0) begin
                    check("inst_addr", k, 32'(t_ia[k]), 32'(mq[k][0].ia));
                    check("inst_data", k, 32'(t_id[k]), 32'(mq[k][0].id));
                    check("arg_addr", k, 32'(t_aa[k]), 32'(mq[k][0].aa));
                    check("arg_data", k, 32'(t_ad[k]), 32'(mq[k][0].ad));
                    check("arg_valid", k, 32'(t_av[k]), 32'(mq[k][0].av));
                    check("arg_wr", k, 32'(t_aw[k]), 32'(mq[k][0].aw));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        FETCH = 0; DECODE = 0; EXECUTE = 0; COMMIT = 0;
        RD = 0; WR = 0; CLEAR = 0; POP = 0;
    endtask

    task automatic instr(input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] aa, input logic [15:0] ad,
                         input logic rd, input logic wr);
        idle_in(); DECODE = 1; ADDR = a; DIN = d;
        tick();
        idle_in(); COMMIT = 1; ADDR = aa; DIN = ad; RD = rd; WR = wr;
        tick();
        idle_in();
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_valid"}, k, 32'(t_v[k]), 0);
            check({tag, "_count"}, k, 32'(t_c[k]), 0);
            check({tag, "_ovf"}, k, 32'(t_ovf[k]), 0);
            check({tag, "_bp"}, k, 32'(t_bp[k]), 0);
            check({tag, "_ia"}, k, 32'(t_ia[k]), 0);
            check({tag, "_id"}, k, 32'(t_id[k]), 0);
            check({tag, "_aa"}, k, 32'(t_aa[k]), 0);
            check({tag, "_ad"}, k, 32'(t_ad[k]), 0);
            check({tag, "_av"}, k, 32'(t_av[k]), 0);
            check({tag, "_aw"}, k, 32'(t_aw[k]), 0);
        end
    endtask

    initial begin
        idle_in();
        RESET = 1; ENABLE = 0; BP_EN = 0; BP_ADDR = 0; ADDR = 0; DIN = 0;
        tick();
        chk_en = 1;
        tick();
        check_zero("reset");
        RESET = 0; ENABLE = 1;
        tick();

        // basic capture with a read argument
        instr(16'h0100, 16'h1234, 16'h8000, 16'hBEEF, 1, 0);
        for (int k = 0; k < 2; k++) begin
            check("basic_valid", k, 32'(t_v[k]), 1);
            check("basic_ia", k, 32'(t_ia[k]), 32'h0100);
            check("basic_id", k, 32'(t_id[k]), 32'h1234);
            check("basic_aa", k, 32'(t_aa[k]), 32'h8000);
            check("basic_ad", k, 32'(t_ad[k]), 32'hBEEF);
            check("basic_av", k, 32'(t_av[k]), 1);
            check("basic_aw", k, 32'(t_aw[k]), 0);
            check("basic_count", k, 32'(t_c[k]), 1);
        end

        // instruction without a bus argument
        instr(16'h0102, 16'h5678, 16'h9000, 16'h1111, 0, 0);
        POP = 1; tick(); POP = 0;
        for (int k = 0; k < 2; k++) begin
            check("noarg_ia", k, 32'(t_ia[k]), 32'h0102);
            check("noarg_av", k, 32'(t_av[k]), 0);
            check("noarg_aa", k, 32'(t_aa[k]), 0);
            check("noarg_ad", k, 32'(t_ad[k]), 0);
            check("noarg_count", k, 32'(t_c[k]), 1);
        end
        CLEAR = 1; tick(); CLEAR = 0;

        // fill past capacity: stop keeps 1..4, ring keeps 3..6
        for (int i = 1; i <= 6; i++) begin
            instr(16'(i), 16'(16'hA000 + i), 16'(16'h0010 + i), 16'(i * 3), 1'(i % 2), 1'((i + 1) % 2));
        end
        for (int k = 0; k < 2; k++) begin
            check("fill_count", k, 32'(t_c[k]), 4);
            check("fill_ovf", k, 32'(t_ovf[k]), 1);
        end
        for (int j = 0; j < 4; j++) begin
            check("fill_stop_head", 0, 32'(t_ia[0]), 32'(j + 1));
            check("fill_ring_head", 1, 32'(t_ia[1]), 32'(j + 3));
            POP = 1; tick(); POP = 0;
        end
        CLEAR = 1; tick(); CLEAR = 0;

        // breakpoint at 0x0204 freezes capture
        BP_EN = 1; BP_ADDR = 16'h0204;
        for (int a = 16'h0200; a <= 16'h020A; a += 2) begin
            instr(16'(a), 16'(a ^ 16'h5A5A), 16'h4000, 16'(a), 0, 1);
        end
        for (int k = 0; k < 2; k++) begin
            check("bp_count", k, 32'(t_c[k]), 3);
            check("bp_hit", k, 32'(t_bp[k]), 1);
        end
        POP = 1; tick(); tick(); POP = 0;
        for (int k = 0; k < 2; k++) check("bp_last", k, 32'(t_ia[k]), 32'h0204);
        BP_EN = 0;
        CLEAR = 1; tick(); CLEAR = 0;
        COMMIT = 1; tick(); COMMIT = 0;
        for (int k = 0; k < 2; k++) begin
            check("bpclr_count", k, 32'(t_c[k]), 0);
            check("bpclr_hit", k, 32'(t_bp[k]), 0);
        end
        instr(16'h0300, 16'h0001, 16'h0, 16'h0, 0, 0);
        for (int k = 0; k < 2; k++) check("resume_count", k, 32'(t_c[k]), 1);
        CLEAR = 1; tick(); CLEAR = 0;

        // simultaneous push and pop while full
        for (int i = 0; i < 4; i++) instr(16'(16'h0400 + i), 16'(i), 16'h0, 16'h0, 1, 0);
        idle_in(); DECODE = 1; ADDR = 16'h0500; DIN = 16'hCAFE; tick();
        idle_in(); COMMIT = 1; POP = 1; RD = 1; ADDR = 16'h7000; DIN = 16'h0042; tick();
        idle_in();
        for (int k = 0; k < 2; k++) begin
            check("pp_count", k, 32'(t_c[k]), 4);
            check("pp_ovf", k, 32'(t_ovf[k]), 0);
            check("pp_head", k, 32'(t_ia[k]), 32'h0401);
        end

        // reset mid-run overrides clear, pop and push
        RESET = 1; COMMIT = 1; POP = 1; CLEAR = 1; tick();
        RESET = 0; idle_in();
        check_zero("midreset");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int ph;
            int rw;
            idle_in();
            ph = $urandom_range(0, 4);
            FETCH   = (ph == 1);
            DECODE  = (ph == 2);
            EXECUTE = (ph == 3);
            COMMIT  = (ph == 4);
            ADDR = 16'($urandom_range(0, 7) * 2);
            DIN  = 16'($urandom());
            rw = $urandom_range(0, 3);
            RD = rw[0];
            WR = rw[1];
            POP   = ($urandom_range(0, 2) == 0);
            CLEAR = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 99) == 0) BP_EN = ~BP_EN;
            if ($urandom_range(0, 19) == 0) BP_ADDR = 16'($urandom_range(0, 7) * 2);
            RESET = ($urandom_range(0, 299) == 0);
            tick();
        end
        RESET = 0;
        idle_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
